sw_event_master: RTL and testbench

//  Avalon-MM master that services the switch PIO slave (18-bit edge-capture input port with irq).

---
 rtl/sw_event_master.sv | 201 ++++++++++++++++++++
 tb/tb_sw_event_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_event_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : sw_event_master
// Brief   : Avalon-MM master for an edge-capture PIO; queues {edges, level}
//           events in a first-word-fall-through FIFO with a valid/ready output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module sw_event_master #(
    parameter int                DATA_W     = 18,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] MASK_INIT  = 18'h3FFFF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic              irq_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_edges,
    output logic [DATA_W-1:0] evt_level,
    output logic              init_done,
    output logic              busy
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] c_INIT_MASK = 4'd0;
    localparam logic [3:0] c_INIT_CLR  = 4'd1;
    localparam logic [3:0] c_IDLE      = 4'd2;
    localparam logic [3:0] c_RD_CAP    = 4'd3;
    localparam logic [3:0] c_W_CAP     = 4'd4;
    localparam logic [3:0] c_CLR_CAP   = 4'd5;
    localparam logic [3:0] c_RD_LVL    = 4'd6;
    localparam logic [3:0] c_W_LVL     = 4'd7;
    localparam logic [3:0] c_PUSH      = 4'd8;

    logic [3:0]         r_state;
    logic [1:0]         r_addr;
    logic               r_read;
    logic               r_write;
    logic [31:0]        r_wdata;
    logic               r_init_done;
    logic [DATA_W-1:0]  r_edges;
    logic [DATA_W-1:0]  r_level;

    logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    // Requests for the chained accesses are raised on the transition into the
    // access state so the irq-to-event path stays within its latency budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_INIT_MASK;
            r_addr      <= 2'd0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
            r_init_done <= 1'b0;
            r_edges     <= '0;
            r_level     <= '0;
        end else begin
            case (r_state)
                c_INIT_MASK: begin
                    if (!r_write) begin
                        r_write <= 1'b1;
                        r_addr  <= 2'd2;
                        r_wdata <= 32'(MASK_INIT);
                    end else if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_state <= c_INIT_CLR;
                    end
                end
                c_INIT_CLR: begin
                    if (!r_write) begin
                        r_write <= 1'b1;
                        r_addr  <= 2'd3;
                        r_wdata <= 32'd0;
                    end else if (!avm_waitrequest) begin
                        r_write     <= 1'b0;
                        r_init_done <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (irq_in && (r_count != c_FULL)) begin
                        r_read  <= 1'b1;
                        r_addr  <= 2'd3;
                        r_state <= c_RD_CAP;
                    end
                end
                c_RD_CAP: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= c_W_CAP;
                    end
                end
                c_W_CAP: begin
                    if (avm_readdatavalid) begin
                        r_edges <= avm_readdata[DATA_W-1:0];
                        r_write <= 1'b1;
                        r_addr  <= 2'd3;
                        r_wdata <= 32'd0;
                        r_state <= c_CLR_CAP;
                    end
                end
                c_CLR_CAP: begin
                    if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        if (r_edges == '0) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_read  <= 1'b1;
                            r_addr  <= 2'd0;
                            r_state <= c_RD_LVL;
                        end
                    end
                end
                c_RD_LVL: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= c_W_LVL;
                    end
                end
                c_W_LVL: begin
                    if (avm_readdatavalid) begin
                        r_level <= avm_readdata[DATA_W-1:0];
                        r_state <= c_PUSH;
                    end
                end
                c_PUSH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_state <= c_INIT_MASK;
                end
            endcase
        end
    end

    // IDLE only leaves with a free slot, so PUSH can never overflow.
    assign w_push = (r_state == c_PUSH);
    assign w_pop  = evt_valid && evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_edges, r_level};
        end
    end

    generate
        if (DATA_W < 32) begin : g_unused_rd
            logic w_unused_rd;
            assign w_unused_rd = ^avm_readdata[31:DATA_W];
        end
    endgenerate

    assign avm_address   = r_addr;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = r_wdata;
    assign evt_valid     = (r_count != '0);
    assign {evt_edges, evt_level} = r_mem[r_rd_ptr];
    assign init_done     = r_init_done;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sw_event_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_sw_event_master
// Brief   : Self-checking bench for sw_event_master with a behavioural PIO slave.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sw_event_master;

    localparam int c_DW = 18;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    logic              irq_in;
    logic              evt_valid;
    logic              evt_ready;
    logic [c_DW-1:0]   evt_edges;
    logic [c_DW-1:0]   evt_level;
    logic              init_done;
    logic              busy;

    sw_event_master #(.DATA_W(c_DW), .FIFO_DEPTH(4), .MASK_INIT(18'h3FFFF)) dut (
        .clk(clk), .reset(reset),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .irq_in(irq_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_edges(evt_edges), .evt_level(evt_level),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural PIO slave: edge capture, mask, pins, stall and read latency.
    logic [c_DW-1:0] r_cap = '0;
    logic [c_DW-1:0] r_mask = '0;
    logic [c_DW-1:0] pins = '0;
    logic [c_DW-1:0] inj = '0;
    logic            irq_force = 1'b0;
    int              ws_cfg = 0;
    int              rd_lat = 1;
    int              r_ws_cnt = 0;
    int              r_dcnt = 0;
    logic            r_pend = 1'b0;
    logic [31:0]     r_rval = '0;
    logic            r_stalled = 1'b0;
    logic [35:0]     r_snap = '0;
    int              r_stab_err = 0;
    logic [34:0]     bus_log[$];
    logic [35:0]     exp_q[$];
    logic            w_req;
    logic            w_acc;
    logic [31:0]     w_rd_val;

    assign w_req           = avm_read || avm_write;
    assign avm_waitrequest = w_req && (r_ws_cnt < ws_cfg);
    assign w_acc           = w_req && !avm_waitrequest;
    assign irq_in          = (|(r_cap & r_mask)) | irq_force;
    assign w_rd_val        = (avm_address == 2'd3) ? {14'h1ABC, r_cap} :
                             (avm_address == 2'd0) ? {14'h2BCD, pins} : {14'h0, r_mask};

    initial begin
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
    end

    always @(posedge clk) begin
        avm_readdatavalid <= 1'b0;
        r_cap <= r_cap | inj;
        if (reset) begin
            r_pend    <= 1'b0;
            r_ws_cnt  <= 0;
            r_stalled <= 1'b0;
        end else begin
            if (r_stalled && ({avm_read, avm_write, avm_address, avm_writedata} != r_snap))
                r_stab_err <= r_stab_err + 1;
            r_stalled <= avm_waitrequest;
            r_snap    <= {avm_read, avm_write, avm_address, avm_writedata};
            r_ws_cnt  <= avm_waitrequest ? r_ws_cnt + 1 : 0;
            if (w_acc) begin
                bus_log.push_back({avm_write, avm_address, avm_writedata});
                if (avm_write) begin
                    if (avm_address == 2'd2) r_mask <= avm_writedata[c_DW-1:0];
                    if (avm_address == 2'd3) r_cap  <= inj;
                end else if (rd_lat <= 1) begin
                    avm_readdatavalid <= 1'b1;
                    avm_readdata      <= w_rd_val;
                end else begin
                    r_pend <= 1'b1;
                    r_dcnt <= rd_lat - 1;
                    r_rval <= w_rd_val;
                end
            end else if (r_pend) begin
                r_dcnt <= r_dcnt - 1;
                if (r_dcnt == 1) begin
                    avm_readdatavalid <= 1'b1;
                    avm_readdata      <= r_rval;
                    r_pend            <= 1'b0;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic test_reset;
        evt_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({avm_read, avm_write, avm_address, avm_writedata} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_avm: got %h expected 0", {avm_read, avm_write, avm_address, avm_writedata});
        end
        n_cmp++;
        if ({evt_valid, init_done, busy} !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_status: got %b expected 001", {evt_valid, init_done, busy});
        end
    endtask

    task automatic test_init;
        int t = 0;
        reset = 1'b0;
        while (!init_done && t < 20) begin @(negedge clk); t++; end
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL init_done: got %b expected 1", init_done);
        end
        n_cmp++;
        if (bus_log.size() != 2) begin
            n_bad++;
            $display("FAIL init_count: got %0d expected 2", bus_log.size());
        end else begin
            n_cmp++;
            if (bus_log[0] !== {1'b1, 2'd2, 32'h3FFFF}) begin
                n_bad++;
                $display("FAIL init_mask_wr: got %h expected %h", bus_log[0], {1'b1, 2'd2, 32'h3FFFF});
            end
            n_cmp++;
            if (bus_log[1] !== {1'b1, 2'd3, 32'h0}) begin
                n_bad++;
                $display("FAIL init_clr_wr: got %h expected %h", bus_log[1], {1'b1, 2'd3, 32'h0});
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL init_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single_event(input logic [c_DW-1:0] e, input logic [c_DW-1:0] l, input int ws);
        int t = 0;
        ws_cfg = ws;
        pins = l;
        bus_log.delete();
        exp_q.push_back({e, l});
        inj = e;
        @(negedge clk);
        inj = '0;
        while (!evt_valid && t < 80) begin @(negedge clk); t++; end
        n_cmp++;
        if (!evt_valid || (ws == 0 && t > 8)) begin
            n_bad++;
            $display("FAIL event_latency ws=%0d: valid=%b after %0d cycles, required within 8 (ws=0)", ws, evt_valid, t);
        end
        n_cmp++;
        if (bus_log.size() != 3) begin
            n_bad++;
            $display("FAIL event_bus_count: got %0d expected 3", bus_log.size());
        end else begin
            n_cmp++;
            if ({bus_log[0][34:32], bus_log[1], bus_log[2][34:32]} !== {3'b011, 1'b1, 2'd3, 32'd0, 3'b000}) begin
                n_bad++;
                $display("FAIL event_bus_seq: got %h %h %h expected rd3, wr3=0, rd0",
                         bus_log[0], bus_log[1], bus_log[2]);
            end
        end
        n_cmp++;
        if (r_stab_err != 0) begin
            n_bad++;
            $display("FAIL stall_stability: got %0d changes expected 0", r_stab_err);
        end
        ws_cfg = 0;
    endtask

    task automatic test_drain(input int n);
        logic [35:0] ev;
        evt_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!evt_valid && t < 40) begin @(negedge clk); t++; end
            n_cmp++;
            if (!evt_valid || exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL drain_valid: valid=%b queued=%0d expected valid with pending entry", evt_valid, exp_q.size());
            end else begin
                ev = exp_q.pop_front();
                n_cmp++;
                if ({evt_edges, evt_level} !== ev) begin
                    n_bad++;
                    $display("FAIL drain_data: got edges=%h level=%h expected edges=%h level=%h",
                             evt_edges, evt_level, ev[35:18], ev[17:0]);
                end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: evt_valid got %b expected 0", evt_valid);
        end
    endtask

    task automatic test_fifo_full;
        logic [35:0] ev;
        logic [c_DW-1:0] e;
        int t;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e = c_DW'((i + 1) * 32'h111);
            pins = e ^ 18'h3FFFF;
            exp_q.push_back({e, e ^ 18'h3FFFF});
            bus_log.delete();
            inj = e;
            @(negedge clk);
            inj = '0;
            t = 0;
            if (i < 4) begin
                while (!(bus_log.size() == 3 && !busy) && t < 40) begin @(negedge clk); t++; end
                n_cmp++;
                if (bus_log.size() != 3 || busy) begin
                    n_bad++;
                    $display("FAIL fill_service %0d: bus ops=%0d busy=%b expected 3 ops, idle", i, bus_log.size(), busy);
                end
            end else begin
                repeat (20) @(negedge clk);
                n_cmp++;
                if (bus_log.size() != 0 || busy || !irq_in) begin
                    n_bad++;
                    $display("FAIL full_hold: bus ops=%0d busy=%b irq=%b expected 0 ops, idle, irq pending",
                             bus_log.size(), busy, irq_in);
                end
            end
        end
        ev = exp_q.pop_front();
        n_cmp++;
        if (!evt_valid || {evt_edges, evt_level} !== ev) begin
            n_bad++;
            $display("FAIL full_pop: valid=%b got %h expected %h", evt_valid, {evt_edges, evt_level}, ev);
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        t = 0;
        while (!(bus_log.size() == 3 && !busy) && t < 40) begin @(negedge clk); t++; end
        n_cmp++;
        if (bus_log.size() != 3 || busy) begin
            n_bad++;
            $display("FAIL full_resume: bus ops=%0d busy=%b expected 3 ops, idle", bus_log.size(), busy);
        end
    endtask

    task automatic test_spurious;
        int t = 0;
        bus_log.delete();
        irq_force = 1'b1;
        while (bus_log.size() < 1 && t < 10) begin @(negedge clk); t++; end
        irq_force = 1'b0;
        t = 0;
        while (!(bus_log.size() >= 2 && !busy) && t < 30) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus_log.size() != 2) begin
            n_bad++;
            $display("FAIL spurious_count: got %0d expected 2", bus_log.size());
        end else begin
            n_cmp++;
            if ({bus_log[0][34:32], bus_log[1]} !== {3'b011, 1'b1, 2'd3, 32'd0}) begin
                n_bad++;
                $display("FAIL spurious_seq: got %h %h expected rd3, wr3=0", bus_log[0], bus_log[1]);
            end
        end
        n_cmp++;
        if ({evt_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL spurious_nopush: valid,busy got %b expected 00", {evt_valid, busy});
        end
    endtask

    task automatic test_reset_mid;
        int t = 0;
        evt_ready = 1'b0;
        pins = 18'h12345;
        exp_q.push_back({18'h00100, 18'h12345});
        bus_log.delete();
        inj = 18'h00100;
        @(negedge clk);
        inj = '0;
        while (!(bus_log.size() == 3 && !busy) && t < 40) begin @(negedge clk); t++; end
        rd_lat = 10;
        bus_log.delete();
        inj = 18'h00002;
        @(negedge clk);
        inj = '0;
        t = 0;
        while (bus_log.size() < 1 && t < 10) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({evt_valid, busy, avm_read, avm_write} !== 4'b1100) begin
            n_bad++;
            $display("FAIL pre_reset_wcap: valid,busy,rd,wr got %b expected 1100", {evt_valid, busy, avm_read, avm_write});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({avm_read, avm_write, avm_address, avm_writedata, evt_valid, init_done, busy} !== {38'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h",
                     {avm_read, avm_write, avm_address, avm_writedata, evt_valid, init_done, busy}, {38'd0, 1'b1});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        bus_log.delete();
        rd_lat = 1;
        reset = 1'b0;
        t = 0;
        while (!init_done && t < 20) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus_log.size() != 2) begin
            n_bad++;
            $display("FAIL reinit_count: got %0d expected 2", bus_log.size());
        end else begin
            n_cmp++;
            if ({bus_log[0], bus_log[1]} !== {1'b1, 2'd2, 32'h3FFFF, 1'b1, 2'd3, 32'h0}) begin
                n_bad++;
                $display("FAIL reinit_seq: got %h %h expected wr2=3ffff, wr3=0", bus_log[0], bus_log[1]);
            end
        end
        n_cmp++;
        if ({init_done, evt_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL reinit_state: init,valid,busy got %b expected 100", {init_done, evt_valid, busy});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_init;
        test_single_event(18'h00005, 18'h3FFFA, 0);
        test_drain(1);
        test_single_event(18'h00005, 18'h3FFFA, 3);
        test_drain(1);
        test_fifo_full;
        test_drain(4);
        test_spurious;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
